l2_port_sched: RTL and testbench
================================

// Module: l2_port_sched
// PURPOSE
//  Round-robin scheduler sharing the single L2 request port among N_REQ L1-side requesters
//  (idx0 = l1i, idx1 = l1d, idx2 = page-table walker). Requests are buffered per requester.
//  At most one transaction is outstanding at L2. The L2 response is routed back to the owner.
//  Sits between the L1s/PTW and l2; provides a grant-inhibit for the flush sequencer.
// PARAMETERS
//  N_REQ    3           number of requesters (2..4)
//  AW       `M_WIDTH    request address width
//  DW       128         store-data width (L1 line, 1<<(`LG_L1D_CL_LEN+3))
// PORTS
//  clk             in   1          clock
//  reset           in   1          synchronous active-high reset
//  req_valid       in   N_REQ      one-cycle request pulse per requester
//  req_addr        in   N_REQ*AW   per-requester address, slice i; sampled on req_valid[i]
//  req_opcode      in   N_REQ*4    per-requester opcode; sampled on req_valid[i]
//  req_store_data  in   DW         store data (requester 1 only); sampled on req_valid[1]
//  req_ack         out  N_REQ      one-cycle pulse: request i granted to L2
//  rsp_valid       out  N_REQ      one-cycle pulse: L2 response belongs to requester i
//  grant_inhibit   in   1          flush sequencer: no new grants while high
//  busy            out  1          any pending request or transaction in flight
//  l2_req_valid    out  1          request to L2; held until l2_req_ack
//  l2_req_ack      in   1          L2 accepted request
//  l2_req_addr     out  AW         granted address
//  l2_req_opcode   out  4          granted opcode
//  l2_req_store_data out DW        captured store data of requester 1
//  l2_rsp_valid    in   1          L2 transaction complete (data on l2 load bus, not routed here)
//  grant_count     out  N_REQ*64   per-requester grant counters (see CONFIGURATION)
//  stall_cycles    out  64         cycles with pending work but no grant possible
// BEHAVIOUR
//  - Reset: state IDLE; pending, req_ack, rsp_valid, l2_req_valid, busy = 0; rr_last = N_REQ-1;
//    addr/opcode/data buffers and l2_req_addr/opcode/store_data = 0; counters = 0.
//    Reset mid-transaction discards everything; an L2 response arriving after reset is ignored.
//  - Buffering: on req_valid[i], set pending[i] and capture addr/opcode (data too for i=1).
//    If req_valid[i] arrives while pending[i] or in flight for i: protocol error; the pulse is
//    ignored and a sim-only $error fires.
//  - Effective pending: n_pend = pending | req_valid, so a pulse in an IDLE cycle can win that cycle.
//  - FSM:
//    IDLE: if n_pend != 0 and !grant_inhibit, select the first set bit scanning from
//      (rr_last+1) mod N_REQ upward with wrap. Then: load l2_req_* from that buffer (bypass if
//      same-cycle pulse), pulse req_ack[g], clear pending[g], set rr_last = g, go ISSUE with
//      l2_req_valid = 1 the next cycle.
//    ISSUE: hold l2_req_valid/addr/opcode stable. When l2_req_ack = 1, drop l2_req_valid next
//      cycle and go WAIT. If l2_rsp_valid arrives in the same cycle as (or before) the ack,
//      route it and go IDLE.
//    WAIT: on l2_rsp_valid, pulse rsp_valid[g] that same cycle (combinational) and go IDLE.
//  - Response -> next grant: one IDLE cycle minimum (no back-to-back grant in the response cycle).
//  - Latency: pulse at cycle t with port idle -> req_ack and l2_req_valid seen high at t+1.
//  - grant_inhibit: gates IDLE grants only; an in-flight transaction completes normally.
//    Pending requests stay buffered and are granted after inhibit falls.
//  - busy = |pending | (state != IDLE).
//  - Fairness: a continuously pending requester waits at most N_REQ-1 grants.
// CONFIGURATION
//  L2_SCHED_PERF_EN defined:
//    - grant_count[i] increments (64-bit, wraps) on each req_ack[i].
//    - stall_cycles increments whenever n_pend != 0 and (state != IDLE or grant_inhibit).
//  Undefined: grant_count and stall_cycles are tied to 0, no counter flops. Ports always exist.
// TESTING
//  1. Reset; pulse req_valid=3'b010, addr 0x1000, opcode 4'd7, data 0xAB.. at t ->
//     req_ack=010 and l2_req_valid at t+1, addr 0x1000, op 7; ack at t+3; rsp at t+6 ->
//     rsp_valid=010 at t+6; busy=0 at t+7.
//  2. Pulse 3'b111 at the same cycle (rr_last=2) -> grant order 0,1,2. Each grant waits
//     for its response plus one IDLE cycle; addresses match the captured slices.
//  3. Requester 0 re-pulses right after each of its responses while 1 and 2 stay pending ->
//     grants are 0,1,2,0,1,2; never two grants to 0 in a row.
//  4. grant_inhibit=1 with 3'b011 pending -> no req_ack, busy=1; deassert -> grant
//     within 1 cycle to idx0.
//  5. l2_rsp_valid in the same cycle as l2_req_ack -> single rsp_valid pulse, state IDLE
//     next cycle, no WAIT.
//  6. Reset asserted during WAIT, then a stray l2_rsp_valid -> no rsp_valid, pending=0.
//     With PERF_EN, scenario 2 ends with grant_count = {1,1,1}.

Source files
------------

// File: rtl/l2_port_sched.sv
// l2_port_sched: round-robin arbiter sharing one L2 request port among N_REQ buffered requesters.
// Ports: clk/reset (sync, active high); req_valid/req_addr/req_opcode/req_store_data buffered per requester;
// req_ack marks a grant and rsp_valid routes the L2 response back to its owner. grant_inhibit blocks new
// grants and busy reports pending or in-flight work. l2_req_* is the L2 request/handshake and l2_rsp_valid
// marks L2 completion. grant_count/stall_cycles are the perf counters.
// Optional feature macro: L2_SCHED_PERF_EN enables the counters; otherwise they read as zero.
`ifndef M_WIDTH
`define M_WIDTH 64
`endif
module l2_port_sched #(
  parameter int N_REQ = 3,
  parameter int AW = `M_WIDTH,
  parameter int DW = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*4-1:0] req_opcode,
  input  logic [DW-1:0]      req_store_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic               grant_inhibit,
  output logic               busy,
  output logic               l2_req_valid,
  input  logic               l2_req_ack,
  output logic [AW-1:0]      l2_req_addr,
  output logic [3:0]         l2_req_opcode,
  output logic [DW-1:0]      l2_req_store_data,
  input  logic               l2_rsp_valid,
  output logic [N_REQ*64-1:0] grant_count,
  output logic [63:0]        stall_cycles
);
  localparam int RW = (N_REQ > 2) ? 2 : 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  logic [1:0] state;
  logic [N_REQ-1:0] pending, owner_oh, err, acc, n_pend, gnt_oh;
  logic [RW-1:0] rr_last, gnt;
  logic gnt_en;
  logic [AW-1:0] addr_q [N_REQ];
  logic [3:0] op_q [N_REQ];
  logic [DW-1:0] data_q;
  // rr_last doubles as the owner of the in-flight transaction
  always_comb begin
    logic found;
    int idx;
    found = 1'b0;
    idx = 0;
    owner_oh = ONE << rr_last;
    err = req_valid & (pending | ((state != IDLE) ? owner_oh : '0));
    acc = req_valid & ~err;
    n_pend = pending | acc;
    gnt_en = (state == IDLE) && (|n_pend) && !grant_inhibit;
    gnt = rr_last;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_last) + k) % N_REQ;
      if (!found && n_pend[idx]) begin
        found = 1'b1;
        gnt = RW'(idx);
      end
    end
    gnt_oh = gnt_en ? (ONE << gnt) : '0;
    rsp_valid = (state != IDLE && l2_rsp_valid) ? owner_oh : '0;
    busy = (|pending) || (state != IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pending <= '0;
      req_ack <= '0;
      l2_req_valid <= 1'b0;
      rr_last <= RW'(N_REQ - 1);
      for (int i = 0; i < N_REQ; i++) begin
        addr_q[i] <= '0;
        op_q[i] <= '0;
      end
      data_q <= '0;
      l2_req_addr <= '0;
      l2_req_opcode <= '0;
      l2_req_store_data <= '0;
    end else begin
      req_ack <= gnt_oh;
      pending <= n_pend & ~gnt_oh;
      for (int i = 0; i < N_REQ; i++)
        if (acc[i]) begin
          addr_q[i] <= req_addr[i*AW +: AW];
          op_q[i] <= req_opcode[i*4 +: 4];
        end
      if (acc[1]) data_q <= req_store_data;
      if (gnt_en) begin
        // a same-cycle pulse bypasses its not-yet-written buffer
        rr_last <= gnt;
        state <= ISSUE;
        l2_req_valid <= 1'b1;
        l2_req_addr <= acc[gnt] ? req_addr[int'(gnt)*AW +: AW] : addr_q[gnt];
        l2_req_opcode <= acc[gnt] ? req_opcode[int'(gnt)*4 +: 4] : op_q[gnt];
        if (gnt == RW'(1)) l2_req_store_data <= acc[1] ? req_store_data : data_q;
      end else if (state == ISSUE) begin
        if (l2_rsp_valid) begin
          state <= IDLE;
          l2_req_valid <= 1'b0;
        end else if (l2_req_ack) begin
          state <= WAIT;
          l2_req_valid <= 1'b0;
        end
      end else if (state == WAIT && l2_rsp_valid) begin
        state <= IDLE;
      end
    end
  end
`ifdef L2_SCHED_PERF_EN
  logic [63:0] gcnt [N_REQ];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) gcnt[i] <= '0;
      stall_cycles <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) if (req_ack[i]) gcnt[i] <= gcnt[i] + 64'd1;
      if ((|n_pend) && (state != IDLE || grant_inhibit)) stall_cycles <= stall_cycles + 64'd1;
    end
  end
  for (genvar g = 0; g < N_REQ; g++) assign grant_count[g*64 +: 64] = gcnt[g];
`else
  assign grant_count = '0;
  assign stall_cycles = '0;
`endif
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!reset && |err) $error("l2_port_sched: request pulse while pending or in flight: %b", err);
`endif
endmodule

// File: tb/tb_l2_port_sched.sv
// tb_l2_port_sched: scoreboard-driven checks of grant order, handshake timing, inhibit and reset.
module tb_l2_port_sched;
  localparam int N = 3, AW = 64, DW = 128;
  typedef struct {int idx; logic [AW-1:0] addr; logic [3:0] op;} exp_t;
  logic clk = 0, reset = 1;
  logic [N-1:0] req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*4-1:0] req_opcode = '0;
  logic [DW-1:0] req_store_data = '0;
  logic [N-1:0] req_ack, rsp_valid;
  logic grant_inhibit = 0, busy, l2_req_valid, l2_req_ack = 0, l2_rsp_valid = 0;
  logic [AW-1:0] l2_req_addr;
  logic [3:0] l2_req_opcode;
  logic [DW-1:0] l2_req_store_data;
  logic [N*64-1:0] grant_count;
  logic [63:0] stall_cycles;
  int n_pass = 0, n_total = 0;
  exp_t sb[$];
  l2_port_sched #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_opcode(req_opcode),
    .req_store_data(req_store_data), .req_ack(req_ack), .rsp_valid(rsp_valid),
    .grant_inhibit(grant_inhibit), .busy(busy), .l2_req_valid(l2_req_valid), .l2_req_ack(l2_req_ack),
    .l2_req_addr(l2_req_addr), .l2_req_opcode(l2_req_opcode), .l2_req_store_data(l2_req_store_data),
    .l2_rsp_valid(l2_rsp_valid), .grant_count(grant_count), .stall_cycles(stall_cycles));
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    req_valid = '0;
    l2_req_ack = 0;
    l2_rsp_valid = 0;
    grant_inhibit = 0;
    sb.delete();
    tick();
    tick();
    reset = 0;
  endtask
  task automatic pulse(input logic [N-1:0] v, input int round);
    logic [AW-1:0] a;
    logic [3:0] op;
    for (int i = 0; i < N; i++)
      if (v[i]) begin
        a = AW'(32'h2000 + i * 256 + round * 16);
        op = 4'(i + round * 3 + 1);
        req_addr[i*AW +: AW] = a;
        req_opcode[i*4 +: 4] = op;
        sb.push_back('{i, a, op});
      end
    req_valid = v;
  endtask
  task automatic serve(input int ack_dly, input int rsp_dly, input bit same);
    exp_t e;
    int n;
    logic [N-1:0] oh;
    n = 0;
    while (!l2_req_valid && n < 20) begin
      tick();
      req_valid = '0;
      n++;
    end
    n_total++;
    if (l2_req_valid !== 1'b1) begin
      $display("FAIL grant_timeout got=%b exp=1", l2_req_valid);
      return;
    end else n_pass++;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_underflow got=empty exp=entry");
      return;
    end else n_pass++;
    e = sb.pop_front();
    oh = N'(1) << e.idx;
    n_total++;
    if (req_ack !== oh) $display("FAIL grant_ack got=%b exp=%b", req_ack, oh); else n_pass++;
    n_total++;
    if (l2_req_addr !== e.addr) $display("FAIL grant_addr got=%h exp=%h", l2_req_addr, e.addr); else n_pass++;
    n_total++;
    if (l2_req_opcode !== e.op) $display("FAIL grant_op got=%h exp=%h", l2_req_opcode, e.op); else n_pass++;
    repeat (ack_dly) begin
      tick();
      req_valid = '0;
      n_total++;
      if (l2_req_valid !== 1'b1 || l2_req_addr !== e.addr)
        $display("FAIL issue_hold got=%b/%h exp=1/%h", l2_req_valid, l2_req_addr, e.addr);
      else n_pass++;
    end
    l2_req_ack = 1;
    l2_rsp_valid = same;
    if (same) begin
      #1;
      n_total++;
      if (rsp_valid !== oh) $display("FAIL rsp_same_cycle got=%b exp=%b", rsp_valid, oh); else n_pass++;
    end
    tick();
    l2_req_ack = 0;
    l2_rsp_valid = 0;
    req_valid = '0;
    n_total++;
    if (l2_req_valid !== 1'b0) $display("FAIL valid_drop got=%b exp=0", l2_req_valid); else n_pass++;
    if (!same) begin
      repeat (rsp_dly - 1) tick();
      l2_rsp_valid = 1;
      #1;
      n_total++;
      if (rsp_valid !== oh) $display("FAIL rsp_route got=%b exp=%b", rsp_valid, oh); else n_pass++;
      tick();
      l2_rsp_valid = 0;
    end
    n_total++;
    if (req_ack !== '0) $display("FAIL grant_in_rsp_cycle got=%b exp=000", req_ack); else n_pass++;
  endtask
  task automatic test_reset();
    do_reset();
    n_total++;
    if ({req_ack, rsp_valid, l2_req_valid, busy} !== '0)
      $display("FAIL reset_ctrl got=%b exp=0", {req_ack, rsp_valid, l2_req_valid, busy});
    else n_pass++;
    n_total++;
    if ({l2_req_addr, l2_req_opcode, l2_req_store_data} !== '0) $display("FAIL reset_data got=nonzero exp=0");
    else n_pass++;
    n_total++;
    if ({grant_count, stall_cycles} !== '0) $display("FAIL reset_counters got=nonzero exp=0"); else n_pass++;
  endtask
  task automatic test_single();
    logic [DW-1:0] sd;
    exp_t e;
    sd = {16{8'hAB}};
    req_addr[AW +: AW] = 64'h1000;
    req_opcode[4 +: 4] = 4'd7;
    req_store_data = sd;
    req_valid = 3'b010;
    sb.push_back('{1, 64'h1000, 4'd7});
    tick();
    req_valid = '0;
    e = sb.pop_front();
    n_total++;
    if (req_ack !== 3'b010 || l2_req_valid !== 1'b1)
      $display("FAIL single_grant got=%b/%b exp=010/1", req_ack, l2_req_valid);
    else n_pass++;
    n_total++;
    if (l2_req_addr !== e.addr || l2_req_opcode !== e.op)
      $display("FAIL single_addr_op got=%h/%h exp=%h/%h", l2_req_addr, l2_req_opcode, e.addr, e.op);
    else n_pass++;
    n_total++;
    if (l2_req_store_data !== sd) $display("FAIL single_data got=%h exp=%h", l2_req_store_data, sd); else n_pass++;
    tick();
    n_total++;
    if (req_ack !== '0 || l2_req_valid !== 1'b1)
      $display("FAIL single_hold got=%b/%b exp=000/1", req_ack, l2_req_valid);
    else n_pass++;
    tick();
    l2_req_ack = 1;
    tick();
    l2_req_ack = 0;
    n_total++;
    if (l2_req_valid !== 1'b0) $display("FAIL single_drop got=%b exp=0", l2_req_valid); else n_pass++;
    tick();
    n_total++;
    if (busy !== 1'b1) $display("FAIL single_busy_wait got=%b exp=1", busy); else n_pass++;
    tick();
    l2_rsp_valid = 1;
    #1;
    n_total++;
    if (rsp_valid !== 3'b010) $display("FAIL single_rsp got=%b exp=010", rsp_valid); else n_pass++;
    tick();
    l2_rsp_valid = 0;
    n_total++;
    if (busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", busy); else n_pass++;
  endtask
  task automatic test_all_three();
    logic [N*64-1:0] exp_gc;
    do_reset();
    pulse(3'b111, 0);
    repeat (3) serve(1, 2, 0);
`ifdef L2_SCHED_PERF_EN
    exp_gc = {3{64'd1}};
`else
    exp_gc = '0;
`endif
    n_total++;
    if (grant_count !== exp_gc) $display("FAIL grant_count got=%h exp=%h", grant_count, exp_gc); else n_pass++;
  endtask
  task automatic test_fairness();
    do_reset();
    pulse(3'b111, 0);
    serve(0, 1, 0);
    pulse(3'b001, 1);
    serve(1, 1, 0);
    pulse(3'b010, 1);
    serve(0, 2, 0);
    pulse(3'b100, 1);
    repeat (3) serve(0, 1, 0);
    n_total++;
    if (busy !== 1'b0 || sb.size() != 0)
      $display("FAIL fairness_drain got=%b/%0d exp=0/0", busy, sb.size());
    else n_pass++;
  endtask
  task automatic test_inhibit();
    logic [63:0] exp_st;
    do_reset();
    grant_inhibit = 1;
    pulse(3'b011, 0);
    repeat (3) begin
      tick();
      req_valid = '0;
      n_total++;
      if (req_ack !== '0 || busy !== 1'b1) $display("FAIL inhibit_hold got=%b/%b exp=000/1", req_ack, busy);
      else n_pass++;
    end
`ifdef L2_SCHED_PERF_EN
    exp_st = 64'd3;
`else
    exp_st = 64'd0;
`endif
    n_total++;
    if (stall_cycles !== exp_st) $display("FAIL stall_cycles got=%0d exp=%0d", stall_cycles, exp_st); else n_pass++;
    grant_inhibit = 0;
    tick();
    serve(0, 1, 0);
    serve(2, 1, 0);
  endtask
  task automatic test_same_cycle_rsp();
    pulse(3'b100, 2);
    serve(1, 0, 1);
    n_total++;
    if (busy !== 1'b0) $display("FAIL same_idle got=%b exp=0", busy); else n_pass++;
    l2_rsp_valid = 1;
    #1;
    n_total++;
    if (rsp_valid !== '0) $display("FAIL same_no_wait got=%b exp=000", rsp_valid); else n_pass++;
    tick();
    l2_rsp_valid = 0;
  endtask
  task automatic test_reset_in_wait();
    exp_t e;
    do_reset();
    pulse(3'b001, 3);
    tick();
    req_valid = '0;
    e = sb.pop_front();
    n_total++;
    if (req_ack !== 3'b001 || l2_req_addr !== e.addr)
      $display("FAIL rw_grant got=%b/%h exp=001/%h", req_ack, l2_req_addr, e.addr);
    else n_pass++;
    l2_req_ack = 1;
    tick();
    l2_req_ack = 0;
    tick();
    reset = 1;
    tick();
    tick();
    reset = 0;
    l2_rsp_valid = 1;
    #1;
    n_total++;
    if (rsp_valid !== '0) $display("FAIL rw_stray_rsp got=%b exp=000", rsp_valid); else n_pass++;
    tick();
    l2_rsp_valid = 0;
    n_total++;
    if ({busy, l2_req_valid, req_ack} !== '0)
      $display("FAIL rw_idle got=%b exp=0", {busy, l2_req_valid, req_ack});
    else n_pass++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_fairness();
    test_inhibit();
    test_same_cycle_rsp();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
